// File: rtl/bcd_sseg_mux.sv
// Latches N packed BCD digits + decimal points and scans them onto a common-anode 7-seg display.
// Output registered: shadow/idx changes at edge t appear on an/sseg after edge t+1; no backpressure.
module bcd_sseg_mux #(
  parameter int N_DIGITS     = 4,
  parameter int DIGIT_CYCLES = 100000,
  localparam int IDX_W       = $clog2(N_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   bcd,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [N_DIGITS-1:0]     an,
  output logic [7:0]              sseg,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int                PRE_W    = $clog2(DIGIT_CYCLES);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [N_DIGITS-1:0][3:0] shadow_bcd_q, shadow_bcd_d;
  logic [N_DIGITS-1:0]      shadow_dp_q,  shadow_dp_d;
  logic [PRE_W-1:0]         pre_q,        pre_d;
  logic [IDX_W-1:0]         idx_q,        idx_d;
  logic [N_DIGITS-1:0]      an_q,         an_d;
  logic [7:0]               sseg_q,       sseg_d;
  logic [IDX_W-1:0]         digit_idx_q,  digit_idx_d;

  logic [N_DIGITS-1:0]      blank_mask;
  logic [3:0]               cur_digit;
  logic                     cur_dp;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Shadow capture and slot timing.
  always_comb begin
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    pre_d        = pre_q + PRE_W'(1);
    idx_d        = idx_q;
    if (load) begin
      shadow_bcd_d = bcd;
      shadow_dp_d  = dp_in;
    end
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A digit is a leading zero only if it and everything above it is a bare zero.
  always_comb begin
    logic all_zero_above;
    blank_mask     = '0;
    all_zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      all_zero_above = all_zero_above && (shadow_bcd_q[k] == 4'd0) && !shadow_dp_q[k];
      blank_mask[k]  = blank_lz && (k != 0) && all_zero_above;
    end
  end

  always_comb begin
    cur_digit   = shadow_bcd_q[idx_q];
    cur_dp      = shadow_dp_q[idx_q];
    digit_idx_d = idx_q;
    if (blank_mask[idx_q]) begin
      an_d   = '1;
      sseg_d = 8'hFF;
    end else begin
      an_d   = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q);
      sseg_d = {~cur_dp, seg_decode(cur_digit)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      pre_q        <= '0;
      idx_q        <= '0;
      an_q         <= '1;
      sseg_q       <= 8'hFF;
      digit_idx_q  <= '0;
    end else begin
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      digit_idx_q  <= digit_idx_d;
    end
  end

  assign an        = an_q;
  assign sseg      = sseg_q;
  assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_bcd_sseg_mux.sv
// Scoreboarded bench: a cycle-count reference model predicts every registered output word.
module tb_bcd_sseg_mux;

  localparam int N  = 4;
  localparam int DC = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*N-1:0] bcd;
  logic [N-1:0]  dp_in;
  logic          load;
  logic          blank_lz;
  logic [N-1:0]  an;
  logic [7:0]    sseg;
  logic [IW-1:0] digit_idx;

  bcd_sseg_mux #(.N_DIGITS(N), .DIGIT_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .bcd(bcd), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .an(an), .sseg(sseg), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  an;
    logic [7:0]    sseg;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model state: shown digits, dp flags, and edges elapsed since reset.
  int m_dig[N];
  int m_dp[N];
  int m_cyc;

  function automatic logic [6:0] ref_seg(int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic exp_t ref_out(int slot, bit blz);
    exp_t e;
    bit   blanked;
    blanked = blz && (slot != 0);
    for (int j = slot; j < N; j++)
      if (m_dig[j] != 0 || m_dp[j] != 0) blanked = 0;
    e.idx = IW'(slot);
    if (blanked) begin
      e.an   = '1;
      e.sseg = 8'hFF;
    end else begin
      e.an   = '1;
      e.an[slot] = 1'b0;
      e.sseg = {(m_dp[slot] == 0), ref_seg(m_dig[slot])};
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      e.an = '1; e.sseg = 8'hFF; e.idx = '0;
      exp_q.push_back(e);
      for (int i = 0; i < N; i++) begin m_dig[i] = 0; m_dp[i] = 0; end
      m_cyc = 0;
    end else begin
      exp_q.push_back(ref_out((m_cyc / DC) % N, blank_lz));
      if (load)
        for (int i = 0; i < N; i++) begin
          m_dig[i] = int'(bcd[4*i +: 4]);
          m_dp[i]  = int'(dp_in[i]);
        end
      m_cyc++;
    end
  end

  // Monitor: one output word per edge, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (an !== e.an || sseg !== e.sseg || digit_idx !== e.idx) begin
        n_miss++;
        $display("FAIL scoreboard t=%0t got an=%h sseg=%h idx=%0d, want an=%h sseg=%h idx=%0d",
                 $time, an, sseg, digit_idx, e.an, e.sseg, e.idx);
      end
    end
  end

  task automatic direct_chk(string name, logic [N-1:0] xa, logic [7:0] xs);
    n_vec++;
    if (an !== xa || sseg !== xs) begin
      n_miss++;
      $display("FAIL %s got an=%h sseg=%h, want an=%h sseg=%h", name, an, sseg, xa, xs);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(logic [4*N-1:0] b, logic [N-1:0] d, logic blz);
    bcd = b; dp_in = d; blank_lz = blz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; bcd = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
    cycles(3);
    direct_chk("reset_state", 4'hF, 8'hFF);
    reset = 1'b0;
    cycles(1);
    direct_chk("first_after_reset", 4'hE, 8'hC0);

    do_load(16'h1234, 4'b0000, 1'b0);  cycles(20);
    do_load(16'h0070, 4'b0000, 1'b1);  cycles(16);
    do_load(16'h0070, 4'b0100, 1'b1);  cycles(16);
    do_load(16'h000A, 4'b0000, 1'b0);  cycles(16);
    do_load(16'h0000, 4'b0000, 1'b1);  cycles(16);

    // Inputs change without load: display must not move.
    bcd = 16'h9999; blank_lz = 1'b0;
    cycles(16);
    guard = 0;
    while ((m_cyc % DC) != DC - 1 && guard < 2 * DC) begin cycles(1); guard++; end
    if (guard >= 2 * DC) begin
      n_vec++; n_miss++;
      $display("FAIL wrap_align got guard=%0d, want < %0d", guard, 2 * DC);
    end
    do_load(16'h9999, 4'b0000, 1'b0);  cycles(12);

    // Reset mid-slot on digit 2.
    guard = 0;
    while (!(((m_cyc / DC) % N) == 2 && (m_cyc % DC) == 1) && guard < 4 * N * DC) begin
      cycles(1); guard++;
    end
    if (guard >= 4 * N * DC) begin
      n_vec++; n_miss++;
      $display("FAIL midslot_align got guard=%0d, want < %0d", guard, 4 * N * DC);
    end
    reset = 1'b1;
    cycles(1);
    direct_chk("midslot_reset", 4'hF, 8'hFF);
    reset = 1'b0;
    cycles(10);

    // Randomized traffic, biased toward zeros so blanking is exercised.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 6) == 0);
      for (int i = 0; i < N; i++) begin
        bcd[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp_in[i]      = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      @(negedge clk);
    end
    reset = 1'b0; load = 1'b0;
    cycles(2);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
